spr_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer in front of one single-port RAM (AW-bit address, DW-bit data, WEN=1 write, synchronous read).
- Each requester issues read/write commands over a req/gnt handshake.
- The arbiter registers the winning command onto the RAM pins.
- Read data is routed back to the requester that issued the read, tagged with rvalid.

---
 rtl/spr_pkg.sv | 8 +
 rtl/spr_rr_arb2.sv | 28 ++
 rtl/spr_arbiter.sv | 84 ++++++++
 tb/tb_spr_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/spr_pkg.sv
// Shared constants for the two-requester single-port RAM arbiter.
package spr_pkg;
  localparam int   SPR_AW = 8;
  localparam int   SPR_DW = 16;
  localparam logic REQ0   = 1'b0;
  localparam logic REQ1   = 1'b1;
  localparam int   RD_LAT = 2;
endpackage

// File: rtl/spr_rr_arb2.sv
// Two-way round-robin grant with a last-winner register; grants are forced low in reset.
module spr_rr_arb2
  import spr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       win
);
  logic last_gnt;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      if (req[0] && (!req[1] || last_gnt == REQ1)) gnt[0] = 1'b1;
      else if (req[1])                             gnt[1] = 1'b1;
    end
  end

  assign win = gnt[1] ? REQ1 : REQ0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_gnt <= REQ1;
    else if (|gnt) last_gnt <= win;
  end
endmodule

// File: rtl/spr_arbiter.sv
// Round-robin arbiter/sequencer for one synchronous single-port RAM; read data is
// tagged back to its issuer through an RD_LAT-deep valid/id shift register.
module spr_arbiter
  import spr_pkg::*;
#(
  parameter int AW = SPR_AW,
  parameter int DW = SPR_DW
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data,
  output logic          ram_wen,
  input  logic [DW-1:0] ram_q
);
  logic [1:0]         req, gnt, we;
  logic [1:0][AW-1:0] addr;
  logic [1:0][DW-1:0] wdata;
  logic               win, hs;
  logic [RD_LAT:1]    vld_pipe, id_pipe;

  assign req   = {req1, req0};
  assign we    = {we1, we0};
  assign addr  = {addr1, addr0};
  assign wdata = {wdata1, wdata0};

  spr_rr_arb2 u_arb (
    .clk   (CLK),
    .rst_n (RST_N),
    .req   (req),
    .gnt   (gnt),
    .win   (win)
  );

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];
  assign hs   = |gnt;

  // Idle cycles keep the last address/data on the pins and just drop WEN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ram_wen     <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
    end else begin
      ram_wen <= hs & we[win];
      if (hs) begin
        ram_address <= addr[win];
        ram_data    <= wdata[win];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[1] <= hs & ~we[win];
      id_pipe[1]  <= win;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  assign rvalid0 = vld_pipe[RD_LAT] & (id_pipe[RD_LAT] == REQ0);
  assign rvalid1 = vld_pipe[RD_LAT] & (id_pipe[RD_LAT] == REQ1);
  assign rdata   = ram_q;
endmodule

// File: tb/tb_spr_arbiter.sv
// Directed bench: stimulus pushes expected read returns, a negedge monitor pops and checks them.
module tb_spr_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_wen;
  logic [DW-1:0] rdata, ram_data, ram_q;
  logic [AW-1:0] ram_address;

  int total = 0;
  int bad   = 0;
  logic [DW:0] sb[$];  // {id, data}

  always #5 CLK = ~CLK;

  spr_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .ram_address(ram_address), .ram_data(ram_data), .ram_wen(ram_wen),
    .ram_q(ram_q)
  );

  // Single-port synchronous RAM model.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
  always @(posedge CLK) begin
    if (ram_wen) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (rvalid0 || rvalid1) begin
      logic [DW:0] e;
      if (rvalid0 && rvalid1) chk("rvalid_both", 1, 0);
      if (sb.size() == 0) chk("rvalid_unexpected", {rvalid1, rvalid0}, 0);
      else begin
        e = sb.pop_front();
        chk("rvalid_id", {31'd0, rvalid1}, {31'd0, e[DW]});
        chk("rdata", {16'd0, rdata}, {16'd0, e[DW-1:0]});
      end
    end
  end

  // One command cycle; called at posedge+2, returns at next posedge+2.
  task automatic cyc(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                     input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                     input logic [1:0] eg, input logic [DW-1:0] ed, input bit track);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    chk("gnt", {30'd0, gnt1, gnt0}, {30'd0, eg});
    if (track && eg[0] && !w0) sb.push_back({1'b0, ed});
    if (track && eg[1] && !w1) sb.push_back({1'b1, ed});
    @(posedge CLK); #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0,0,0,0, 0,0,0,0, 2'b00, 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N = 1'b0;
    req0 = 1; we0 = 0; addr0 = 8'h33; wdata0 = 0;
    req1 = 1; we1 = 0; addr1 = 8'h44; wdata1 = 0;
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_gnt", {30'd0, gnt1, gnt0}, 0);
    chk("rst_wen", {31'd0, ram_wen}, 0);
    chk("rst_addr", {24'd0, ram_address}, 0);
    chk("rst_data", {16'd0, ram_data}, 0);
    chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 0);
    RST_N = 1'b1;

    // Write then read back through requester 0
    cyc(1,1,8'h00,16'h00F0, 0,0,0,0, 2'b01, 0, 1);
    chk("wr_wen", {31'd0, ram_wen}, 1);
    chk("wr_addr", {24'd0, ram_address}, 8'h00);
    chk("wr_data", {16'd0, ram_data}, 16'h00F0);
    cyc(1,0,8'h00,0, 0,0,0,0, 2'b01, 16'h00F0, 1);
    chk("rd_wen", {31'd0, ram_wen}, 0);
    chk("rd_addr", {24'd0, ram_address}, 8'h00);
    idle(3);

    // Preload, then both hold reads: alternating grants starting with 0
    cyc(1,1,8'h01,16'h00E1, 0,0,0,0, 2'b01, 0, 1);
    cyc(0,0,0,0, 1,1,8'h02,16'h00D2, 2'b10, 0, 1);
    idle(1);
    chk("idle_wen", {31'd0, ram_wen}, 0);
    chk("idle_addr_hold", {24'd0, ram_address}, 8'h02);
    cyc(1,0,8'h01,0, 1,0,8'h02,0, 2'b01, 16'h00E1, 1);
    cyc(1,0,8'h01,0, 1,0,8'h02,0, 2'b10, 16'h00D2, 1);
    cyc(1,0,8'h01,0, 1,0,8'h02,0, 2'b01, 16'h00E1, 1);
    cyc(1,0,8'h01,0, 1,0,8'h02,0, 2'b10, 16'h00D2, 1);

    // Read-after-write on consecutive cycles
    cyc(0,0,0,0, 1,1,8'h02,16'h1234, 2'b10, 0, 1);
    cyc(1,0,8'h02,0, 0,0,0,0, 2'b01, 16'h1234, 1);

    // req1 alone three times, then contention goes to req0
    cyc(0,0,0,0, 1,0,8'h02,0, 2'b10, 16'h1234, 1);
    cyc(0,0,0,0, 1,0,8'h02,0, 2'b10, 16'h1234, 1);
    cyc(0,0,0,0, 1,0,8'h02,0, 2'b10, 16'h1234, 1);
    cyc(1,0,8'h01,0, 1,0,8'h00,0, 2'b01, 16'h00E1, 1);
    cyc(1,0,8'h01,0, 1,0,8'h00,0, 2'b10, 16'h00F0, 1);
    idle(3);
    chk("sb_drained", sb.size(), 0);

    // Two reads in flight, then reset: leaves last winner = 0
    cyc(0,0,0,0, 1,0,8'h01,0, 2'b10, 0, 0);
    cyc(1,0,8'h02,0, 0,0,0,0, 2'b01, 0, 0);
    req0 = 1; req1 = 0;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_gnt", {30'd0, gnt1, gnt0}, 0);
    chk("mid_rst_wen", {31'd0, ram_wen}, 0);
    chk("mid_rst_addr", {24'd0, ram_address}, 0);
    chk("mid_rst_data", {16'd0, ram_data}, 0);
    chk("mid_rst_rvalid", {30'd0, rvalid1, rvalid0}, 0);
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;
    idle(3);
    cyc(1,0,8'h01,0, 1,0,8'h02,0, 2'b01, 16'h00E1, 1);
    idle(3);
    chk("sb_drained_end", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
